// File: rtl/jedro_1_branch_pkg.sv
// Shared types for the jedro_1 branch resolution unit: RV32I branch funct3
// encodings and the flush FSM states.
package jedro_1_branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } funct3_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/jedro_1_branch_cmp.sv
// Combinational branch condition evaluator. Produces the raw branch
// condition for the six RV32I branch types and flags the two unused funct3
// codes (010, 011) as illegal; cond is forced low for illegal codes.
module jedro_1_branch_cmp
    import jedro_1_branch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    output logic                  cond,
    output logic                  illegal
);

    // Decode funct3 and evaluate the matching comparison.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BEQ:     cond = (rs1 == rs2);
            BNE:     cond = (rs1 != rs2);
            BLT:     cond = ($signed(rs1) <  $signed(rs2));
            BGE:     cond = ($signed(rs1) >= $signed(rs2));
            BLTU:    cond = (rs1 <  rs2);
            BGEU:    cond = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/jedro_1_branch_unit.sv
// Branch resolution unit for the jedro_1 core. Evaluates a conditional
// branch, reports its target, raises a FLUSH_CYCLES-long flush on taken
// branches (stalling new ops meanwhile) and keeps saturating taken /
// not-taken statistics.
module jedro_1_branch_unit
    import jedro_1_branch_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [ADDR_WIDTH-1:0] imm_i,
    input  logic                  clr_cnt_i,
    output logic                  valid_o,
    output logic                  taken_o,
    output logic [ADDR_WIDTH-1:0] target_o,
    output logic                  illegal_o,
    output logic                  misaligned_o,
    output logic                  flush_o,
    output logic [CNT_WIDTH-1:0]  taken_cnt_o,
    output logic [CNT_WIDTH-1:0]  nottaken_cnt_o
);

    localparam int                 FCW        = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0]     FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_e                state;
    logic [FCW-1:0]        flush_cnt;
    logic                  cond;
    logic                  illegal;
    logic                  accept;
    logic                  misaligned;
    logic                  taken;
    logic                  count_taken;
    logic                  count_nottaken;
    logic [ADDR_WIDTH-1:0] target;

    jedro_1_branch_cmp #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cmp (
        .funct3  (funct3_i),
        .rs1     (rs1_i),
        .rs2     (rs2_i),
        .cond    (cond),
        .illegal (illegal)
    );

    // Readiness comes only from FSM state and reset, never from valid_i.
    assign ready_o        = (state == IDLE) && !rst_i;
    assign accept         = valid_i && ready_o;
    assign target         = pc_i + imm_i;
    // A true condition with an unaligned target is reported, not taken.
    assign misaligned     = cond && (target[1:0] != 2'b00);
    assign taken          = cond && !misaligned;
    assign count_taken    = accept && taken;
    assign count_nottaken = accept && !illegal && !cond;

    // Result registers: valid_o pulses one cycle, the rest hold until the next accept.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            valid_o      <= 1'b0;
            taken_o      <= 1'b0;
            target_o     <= '0;
            illegal_o    <= 1'b0;
            misaligned_o <= 1'b0;
        end else begin
            valid_o <= accept;
            if (accept) begin
                taken_o      <= taken;
                target_o     <= target;
                illegal_o    <= illegal;
                misaligned_o <= misaligned;
            end
        end
    end

    // Flush FSM: a taken branch holds flush_o high for FLUSH_CYCLES cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            flush_cnt <= '0;
            flush_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count_taken) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                        flush_o   <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= IDLE;
                        flush_o <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics; a clear request overrides a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            taken_cnt_o    <= '0;
            nottaken_cnt_o <= '0;
        end else begin
            if (count_taken && (taken_cnt_o != CNT_MAX)) begin
                taken_cnt_o <= taken_cnt_o + 1'b1;
            end
            if (count_nottaken && (nottaken_cnt_o != CNT_MAX)) begin
                nottaken_cnt_o <= nottaken_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jedro_1_branch_unit.sv
// Self-checking bench for jedro_1_branch_unit: directed scenarios plus
// randomized traffic, all compared against a cycle-level behavioural model.
// A second small instance (CNT_WIDTH=4, FLUSH_CYCLES=1) covers saturation.
module tb_jedro_1_branch_unit;

    localparam int  FC   = 2;
    localparam int  CW   = 16;
    localparam longint CMAX = (longint'(1) << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance signals
    logic        rst_i = 1'b1, valid_i = 1'b0, clr_cnt_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] rs1_i = '0, rs2_i = '0, pc_i = '0, imm_i = '0;
    logic        ready_o, valid_o, taken_o, illegal_o, misaligned_o, flush_o;
    logic [31:0] target_o;
    logic [15:0] taken_cnt_o, nottaken_cnt_o;

    // Small instance signals
    logic        s_rst = 1'b1, s_valid = 1'b0, s_clr = 1'b0;
    logic [2:0]  s_f3 = 3'b000;
    logic [31:0] s_rs1 = 32'd7, s_rs2 = 32'd7, s_pc = 32'h1000, s_imm = 32'h10;
    logic        s_ready, s_valid_o, s_taken_o, s_illegal_o, s_mis_o, s_flush_o;
    logic [31:0] s_target_o;
    logic [3:0]  s_tcnt, s_ntcnt;

    jedro_1_branch_unit dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .pc_i(pc_i),
        .imm_i(imm_i), .clr_cnt_i(clr_cnt_i), .valid_o(valid_o),
        .taken_o(taken_o), .target_o(target_o), .illegal_o(illegal_o),
        .misaligned_o(misaligned_o), .flush_o(flush_o),
        .taken_cnt_o(taken_cnt_o), .nottaken_cnt_o(nottaken_cnt_o)
    );

    jedro_1_branch_unit #(.CNT_WIDTH(4), .FLUSH_CYCLES(1)) dut_s (
        .clk_i(clk), .rst_i(s_rst), .valid_i(s_valid), .ready_o(s_ready),
        .funct3_i(s_f3), .rs1_i(s_rs1), .rs2_i(s_rs2), .pc_i(s_pc),
        .imm_i(s_imm), .clr_cnt_i(s_clr), .valid_o(s_valid_o),
        .taken_o(s_taken_o), .target_o(s_target_o), .illegal_o(s_illegal_o),
        .misaligned_o(s_mis_o), .flush_o(s_flush_o),
        .taken_cnt_o(s_tcnt), .nottaken_cnt_o(s_ntcnt)
    );

    // Behavioural model state
    int          flush_left = 0;
    bit          m_accepted = 0;
    bit          m_valid = 0, m_taken = 0, m_illegal = 0, m_mis = 0;
    logic [31:0] m_target = '0;
    longint      m_tc = 0, m_ntc = 0;

    function automatic longint as_signed(input logic [31:0] v);
        longint u = longint'(v);
        return v[31] ? u - (longint'(1) << 32) : u;
    endfunction

    // Branch rule straight from the RV32I definitions.
    function automatic void ref_eval(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b, output bit ill, output bit cond);
        longint ua = longint'(a);
        longint ub = longint'(b);
        ill  = 1'b0;
        cond = 1'b0;
        case (f3)
            3'd0: cond = (ua == ub);
            3'd1: cond = (ua != ub);
            3'd4: cond = (as_signed(a) <  as_signed(b));
            3'd5: cond = (as_signed(a) >= as_signed(b));
            3'd6: cond = (ua <  ub);
            3'd7: cond = (ua >= ub);
            default: ill = 1'b1;
        endcase
    endfunction

    // One clock cycle on the main instance: drive, check ready, advance model, check outputs.
    task automatic do_cycle(input string tag, input bit rst, input bit v, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] imm, input bit clr);
        bit exp_ready, ill, cond, mis;
        logic [31:0] tgt;
        rst_i = rst; valid_i = v; funct3_i = f3; rs1_i = a; rs2_i = b;
        pc_i = pc; imm_i = imm; clr_cnt_i = clr;
        @(negedge clk);
        exp_ready = !rst && (flush_left == 0);
        checks++;
        if (ready_o !== exp_ready) begin
            errors++;
            $display("FAIL %s ready_o: got %b expected %b", tag, ready_o, exp_ready);
        end
        m_accepted = v && exp_ready;
        if (rst) begin
            flush_left = 0; m_valid = 0; m_taken = 0; m_illegal = 0; m_mis = 0;
            m_target = '0; m_tc = 0; m_ntc = 0; m_accepted = 0;
        end else begin
            if (flush_left > 0) flush_left--;
            m_valid = m_accepted;
            ill = 0; cond = 0; mis = 0;
            if (m_accepted) begin
                ref_eval(f3, a, b, ill, cond);
                tgt       = 32'((longint'(pc) + longint'(imm)) % (longint'(1) << 32));
                mis       = cond && (tgt % 4 != 0);
                m_taken   = cond && !mis;
                m_illegal = ill;
                m_mis     = mis;
                m_target  = tgt;
                if (m_taken) flush_left = FC;
            end
            if (clr) begin
                m_tc = 0; m_ntc = 0;
            end else if (m_accepted && !ill && !mis) begin
                if (cond) m_tc  = (m_tc  < CMAX) ? m_tc  + 1 : m_tc;
                else      m_ntc = (m_ntc < CMAX) ? m_ntc + 1 : m_ntc;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_o !== m_valid) begin
            errors++; $display("FAIL %s valid_o: got %b expected %b", tag, valid_o, m_valid);
        end
        checks++;
        if (taken_o !== m_taken) begin
            errors++; $display("FAIL %s taken_o: got %b expected %b", tag, taken_o, m_taken);
        end
        checks++;
        if (target_o !== m_target) begin
            errors++; $display("FAIL %s target_o: got %h expected %h", tag, target_o, m_target);
        end
        checks++;
        if (illegal_o !== m_illegal) begin
            errors++; $display("FAIL %s illegal_o: got %b expected %b", tag, illegal_o, m_illegal);
        end
        checks++;
        if (misaligned_o !== m_mis) begin
            errors++; $display("FAIL %s misaligned_o: got %b expected %b", tag, misaligned_o, m_mis);
        end
        checks++;
        if (flush_o !== (flush_left > 0)) begin
            errors++; $display("FAIL %s flush_o: got %b expected %b", tag, flush_o, flush_left > 0);
        end
        checks++;
        if (longint'(taken_cnt_o) !== m_tc) begin
            errors++; $display("FAIL %s taken_cnt_o: got %0d expected %0d", tag, taken_cnt_o, m_tc);
        end
        checks++;
        if (longint'(nottaken_cnt_o) !== m_ntc) begin
            errors++; $display("FAIL %s nottaken_cnt_o: got %0d expected %0d", tag, nottaken_cnt_o, m_ntc);
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) do_cycle(tag, 0, 0, 3'd0, '0, '0, '0, '0, 0);
    endtask

    // Hold an op until it is accepted, bounded to a few cycles.
    task automatic send(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm);
        int n = 0;
        do begin
            do_cycle(tag, 0, 1, f3, a, b, pc, imm, 0);
            n++;
        end while (!m_accepted && n < 8);
        checks++;
        if (!m_accepted) begin
            errors++; $display("FAIL %s accept timeout: got no accept expected accept within 8 cycles", tag);
        end
    endtask

    task automatic test_reset();
        do_cycle("reset", 1, 0, 3'd0, '0, '0, '0, '0, 0);
        do_cycle("reset", 1, 1, 3'd0, '0, '0, '0, '0, 0);
        checks++;
        if (valid_o !== 1'b0 || flush_o !== 1'b0 || taken_cnt_o !== 16'd0 || nottaken_cnt_o !== 16'd0) begin
            errors++; $display("FAIL reset_state: got valid=%b flush=%b tc=%0d ntc=%0d expected all 0",
                               valid_o, flush_o, taken_cnt_o, nottaken_cnt_o);
        end
    endtask

    task automatic test_signed_vs_unsigned();
        send("bge_neg", 3'b101, 32'hFFFF_FFFF, 32'd0, 32'h100, 32'd8);
        checks++;
        if (taken_o !== 1'b0 || target_o !== 32'h108 || nottaken_cnt_o !== 16'd1) begin
            errors++; $display("FAIL bge_neg: got taken=%b target=%h ntc=%0d expected 0 108 1",
                               taken_o, target_o, nottaken_cnt_o);
        end
        send("bgeu_big", 3'b111, 32'hFFFF_FFFF, 32'd0, 32'h100, 32'd8);
        checks++;
        if (taken_o !== 1'b1 || flush_o !== 1'b1 || taken_cnt_o !== 16'd1) begin
            errors++; $display("FAIL bgeu_big: got taken=%b flush=%b tc=%0d expected 1 1 1",
                               taken_o, flush_o, taken_cnt_o);
        end
        idle("flush_n2", 1);
        checks++;
        if (flush_o !== 1'b1 || ready_o !== 1'b0) begin
            errors++; $display("FAIL flush_n2: got flush=%b ready=%b expected 1 0", flush_o, ready_o);
        end
        idle("flush_n3", 1);
        checks++;
        if (flush_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_n3: got flush=%b ready=%b expected 0 1", flush_o, ready_o);
        end
    endtask

    task automatic test_equal_operands();
        logic [2:0] codes [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        bit         exp_t [6] = '{1, 0, 0, 1, 0, 1};
        do_cycle("eq_clr", 0, 0, 3'd0, '0, '0, '0, '0, 1);
        for (int i = 0; i < 6; i++) begin
            send("eq_op", codes[i], 32'd5, 32'd5, 32'h200, 32'h10);
            checks++;
            if (taken_o !== exp_t[i]) begin
                errors++; $display("FAIL eq_op funct3=%b: got taken=%b expected %b", codes[i], taken_o, exp_t[i]);
            end
        end
        idle("eq_drain", 3);
        checks++;
        if (taken_cnt_o !== 16'd3 || nottaken_cnt_o !== 16'd3) begin
            errors++; $display("FAIL eq_counts: got tc=%0d ntc=%0d expected 3 3", taken_cnt_o, nottaken_cnt_o);
        end
    endtask

    task automatic test_back_to_back_illegal();
        logic [15:0] tc0 = taken_cnt_o, ntc0 = nottaken_cnt_o;
        do_cycle("ill_010", 0, 1, 3'b010, 32'd5, 32'd5, 32'h300, 32'h4, 0);
        checks++;
        if (valid_o !== 1'b1 || illegal_o !== 1'b1 || taken_o !== 1'b0 || flush_o !== 1'b0) begin
            errors++; $display("FAIL ill_010: got v=%b ill=%b t=%b f=%b expected 1 1 0 0",
                               valid_o, illegal_o, taken_o, flush_o);
        end
        do_cycle("ill_011", 0, 1, 3'b011, 32'd5, 32'd6, 32'h300, 32'h4, 0);
        checks++;
        if (valid_o !== 1'b1 || illegal_o !== 1'b1 || taken_o !== 1'b0 || flush_o !== 1'b0 ||
            taken_cnt_o !== tc0 || nottaken_cnt_o !== ntc0) begin
            errors++; $display("FAIL ill_011: got v=%b ill=%b t=%b f=%b tc=%0d ntc=%0d expected 1 1 0 0 %0d %0d",
                               valid_o, illegal_o, taken_o, flush_o, taken_cnt_o, nottaken_cnt_o, tc0, ntc0);
        end
        do_cycle("ill_bne", 0, 1, 3'b001, 32'd5, 32'd5, 32'h300, 32'h4, 0);
        checks++;
        if (valid_o !== 1'b1 || illegal_o !== 1'b0 || nottaken_cnt_o !== ntc0 + 16'd1) begin
            errors++; $display("FAIL ill_bne: got v=%b ill=%b ntc=%0d expected 1 0 %0d",
                               valid_o, illegal_o, nottaken_cnt_o, ntc0 + 16'd1);
        end
    endtask

    task automatic test_misaligned();
        logic [15:0] tc0 = taken_cnt_o, ntc0 = nottaken_cnt_o;
        do_cycle("misal", 0, 1, 3'b000, 32'd9, 32'd9, 32'h100, 32'd6, 0);
        checks++;
        if (misaligned_o !== 1'b1 || taken_o !== 1'b0 || target_o !== 32'h106 || flush_o !== 1'b0 ||
            taken_cnt_o !== tc0 || nottaken_cnt_o !== ntc0) begin
            errors++; $display("FAIL misal: got mis=%b t=%b tgt=%h f=%b tc=%0d ntc=%0d expected 1 0 106 0 %0d %0d",
                               misaligned_o, taken_o, target_o, flush_o, taken_cnt_o, nottaken_cnt_o, tc0, ntc0);
        end
        idle("misal_next", 1);
    endtask

    task automatic test_reset_in_flush();
        send("rf_taken", 3'b111, 32'd1, 32'd0, 32'h80, 32'h8);
        do_cycle("rf_rst", 1, 0, 3'd0, '0, '0, '0, '0, 0);
        checks++;
        if (flush_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL rf_rst: got flush=%b valid=%b expected 0 0", flush_o, valid_o);
        end
        do_cycle("rf_bge", 0, 1, 3'b101, 32'd3, 32'd3, 32'h40, 32'h20, 0);
        checks++;
        if (valid_o !== 1'b1 || taken_o !== 1'b1 || target_o !== 32'h60) begin
            errors++; $display("FAIL rf_bge: got v=%b t=%b tgt=%h expected 1 1 60", valid_o, taken_o, target_o);
        end
        idle("rf_drain", 3);
    endtask

    task automatic test_random();
        logic [31:0] pick [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 500; i++) begin
            logic [31:0] a, b, pc, imm;
            logic [2:0]  f3;
            bit          v, clr, rst;
            int          mode;
            f3   = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 3);
            a = $urandom; b = $urandom;
            if (mode == 1) b = a;
            if (mode == 2) begin
                a = pick[$urandom_range(0, 4)];
                b = pick[$urandom_range(0, 4)];
            end
            pc  = $urandom & 32'hFFFF_FFFC;
            imm = ($urandom_range(0, 7) == 0) ? 32'($urandom) : ($urandom & 32'hFFFF_FFFC);
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 99) == 0);
            do_cycle("random", rst, v, f3, a, b, pc, imm, clr);
        end
        idle("rand_drain", 3);
    endtask

    task automatic test_saturation();
        s_rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (s_valid_o !== 1'b1 || s_taken_o !== 1'b1 || s_flush_o !== 1'b1 || s_ready !== 1'b0 ||
                int'(s_tcnt) !== ((i + 1 < 15) ? i + 1 : 15)) begin
                errors++; $display("FAIL sat_op %0d: got v=%b t=%b f=%b r=%b tc=%0d expected 1 1 1 0 %0d",
                                   i, s_valid_o, s_taken_o, s_flush_o, s_ready, s_tcnt,
                                   (i + 1 < 15) ? i + 1 : 15);
            end
            s_valid = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (s_flush_o !== 1'b0 || s_ready !== 1'b1) begin
                errors++; $display("FAIL sat_gap %0d: got f=%b r=%b expected 0 1", i, s_flush_o, s_ready);
            end
        end
        s_valid = 1'b1;
        s_clr   = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_clr   = 1'b0;
        checks++;
        if (s_valid_o !== 1'b1 || s_taken_o !== 1'b1 || s_tcnt !== 4'd0) begin
            errors++; $display("FAIL sat_clr: got v=%b t=%b tc=%0d expected 1 1 0", s_valid_o, s_taken_o, s_tcnt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_signed_vs_unsigned();
        test_equal_operands();
        test_back_to_back_illegal();
        test_misaligned();
        test_reset_in_flush();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jedro_1_branch_unit.md
# jedro_1_branch_unit

Parametrised branch resolution unit for the jedro_1 core. It evaluates all six RV32I conditional branch types (beq, bne, blt, bge, bltu, bgeu) on DATA_WIDTH-bit operands and computes the branch target. It also generates a multi-cycle pipeline flush on taken branches and keeps saturating taken/not-taken statistics. It sits between the decoder/regfile read stage and the instruction fetch unit.

## Interface
Parameters:
- DATA_WIDTH, 32, operand width.
- ADDR_WIDTH, 32, PC/target width.
- FLUSH_CYCLES, 2, cycles flush_o stays high after a taken branch; legal range >= 1.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  branch op presented.
- ready_o  out  1  unit can accept an op.
- funct3_i  in  3  RV32 branch funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
- rs1_i, rs2_i  in  DATA_WIDTH  operands.
- pc_i  in  ADDR_WIDTH  PC of the branch.
- imm_i  in  ADDR_WIDTH  sign-extended branch offset.
- clr_cnt_i  in  1  clear both statistics counters.
- valid_o  out  1  result valid; single-cycle pulse.
- taken_o  out  1  branch taken.
- target_o  out  ADDR_WIDTH  pc_i + imm_i.
- illegal_o  out  1  funct3 is 010 or 011.
- misaligned_o  out  1  condition true but target[1:0] != 0.
- flush_o  out  1  kill younger instructions.
- taken_cnt_o, nottaken_cnt_o  out  CNT_WIDTH  statistics.

## Operation
- Accept: an op is accepted when valid_i && ready_o. If valid_i is high while ready_o is low, the op is ignored and upstream holds it.
- Compare rules:
  - blt/bge compare as DATA_WIDTH-bit two's complement.
  - bltu/bgeu compare unsigned.
  - beq/bne compare bitwise.
- Target: target_o = (pc_i + imm_i) mod 2^ADDR_WIDTH. The target is always reported, even when the branch is not taken.
- Result classification:
  - Illegal funct3: illegal_o=1, taken_o=0, no flush, counters unchanged.
  - Condition true with target[1:0] != 0: misaligned_o=1, taken_o=0, no flush, counters unchanged.
  - Legal and not taken: taken_o=0, nottaken_cnt_o increments.
  - Legal, taken and aligned: taken_o=1, taken_cnt_o increments, FSM enters FLUSH.
- FSM:
  - IDLE: ready_o=1. A taken op moves the FSM to FLUSH and loads the flush counter with FLUSH_CYCLES-1.
  - FLUSH: ready_o=0, flush_o=1. The counter decrements each cycle; the FSM returns to IDLE after the cycle in which the count is 0.
- Counters: saturate at 2^CNT_WIDTH-1. If clr_cnt_i coincides with an increment, the clear wins and the result is 0.
- Reset values:
  - valid_o, taken_o, target_o, illegal_o, misaligned_o, flush_o: 0.
  - Counters: 0.
  - FSM: IDLE.
  - ready_o: 0 while rst_i is high.
- Reset during FLUSH aborts the flush immediately.

## Timing
- Accept at edge N → valid_o and all result outputs registered, visible in cycle N+1, held for exactly one cycle. valid_o then returns to 0 and the other result outputs hold their last value.
- Taken branch accepted at N: flush_o high in cycles N+1 … N+FLUSH_CYCLES. ready_o is low over the same cycles and returns high in cycle N+FLUSH_CYCLES+1.
- Not-taken, illegal or misaligned ops can be accepted back-to-back, one per cycle, with no bubble.
- Counter updates become visible in the same cycle as the corresponding valid_o.
- ready_o depends only on FSM state and rst_i; there is no combinational path from valid_i.
- After rst_i deasserts, ready_o is 1 in the first cycle.

## Structure
- Package jedro_1_branch_pkg holds:
  - funct3 enum: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - FSM state enum: IDLE, FLUSH.
- Sub-module jedro_1_branch_cmp: purely combinational; inputs funct3, rs1, rs2 (DATA_WIDTH parameter); outputs cond and illegal.
- Top level contains: target adder, output registers, FSM with flush counter ($clog2(FLUSH_CYCLES+1) bits), and the two saturating counters.

## Test plan
1. rs1=32'hFFFF_FFFF, rs2=0, pc=0x100, imm=8:
   - bge → taken_o=0, target_o=0x108, nottaken_cnt=1.
   - bgeu → taken_o=1, flush_o high cycles N+1..N+2, ready_o low for the same 2 cycles, taken_cnt=1.
2. rs1=rs2=5, all six funct3 legal codes → beq, bge, bgeu taken; bne, blt, bltu not taken. Final counts: taken_cnt=3, nottaken_cnt=3.
3. funct3=010, then 011 → illegal_o=1, taken_o=0, flush_o=0, counters unchanged. A following bne op is accepted the next cycle.
4. beq with rs1=rs2, pc=0x100, imm=6 → misaligned_o=1, taken_o=0, target_o=0x106, no flush, counters unchanged.
5. CNT_WIDTH=4, FLUSH_CYCLES=1: 20 taken branches → taken_cnt_o=15. Then clr_cnt_i asserted in the same cycle as a taken accept → taken_cnt_o=0.
6. Assert rst_i in the first FLUSH cycle → next cycle flush_o=0 and valid_o=0. ready_o=1 in the first cycle after rst_i drops, and a bge op is accepted immediately.
